// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// One result bit per cycle; the pipeline is frozen through stall_o while it runs.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, neg_res, neg_rem, div_zero;
  logic [XLEN-1:0]   opa, rs_raw;
  logic [2*XLEN-1:0] acc;

  // operand decode at the start edge
  logic            md_start, signed_op, op_is_div;
  logic [XLEN-1:0] rs_mag, rt_mag;

  assign md_start  = start_i && (op_i >= OP_MULT) && (op_i <= OP_DIVU);
  assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign op_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign rs_mag    = (signed_op && rs_data_i[XLEN-1]) ? (XLEN'(0) - rs_data_i) : rs_data_i;
  assign rt_mag    = (signed_op && rt_data_i[XLEN-1]) ? (XLEN'(0) - rt_data_i) : rt_data_i;

  // multiply step: add multiplicand into upper half when LSB set, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // restoring divide step: acc holds {remainder, dividend/quotient bits}
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, opa};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // sign fix-up applied in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_res ? ((2*XLEN)'(0) - acc) : acc;
  assign quot_fix = neg_res ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem_fix  = neg_rem ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_o     <= '0;
      lo_o     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      rs_raw   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy_o <= (state_nxt != IDLE);
      done_o <= (state == FIX);
      case (state)
        IDLE: begin
          if (md_start) begin
            cnt      <= '0;
            is_div   <= op_is_div;
            neg_res  <= signed_op && (rs_data_i[XLEN-1] ^ rt_data_i[XLEN-1]);
            neg_rem  <= signed_op && rs_data_i[XLEN-1];
            div_zero <= (rt_data_i == '0);
            rs_raw   <= rs_data_i;
            opa      <= op_is_div ? rt_mag : rs_mag;
            acc      <= {{XLEN{1'b0}}, (op_is_div ? rs_mag : rt_mag)};
          end else if (start_i && op_i == OP_MTHI) begin
            hi_o <= rs_data_i;
          end else if (start_i && op_i == OP_MTLO) begin
            lo_o <= rs_data_i;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!is_div) begin
            hi_o <= prod_fix[2*XLEN-1:XLEN];
            lo_o <= prod_fix[XLEN-1:0];
          end else if (div_zero) begin
            hi_o <= rs_raw;
            lo_o <= '1;
          end else begin
            hi_o <= rem_fix;
            lo_o <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o = busy_o || (state == IDLE && md_start);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: an arithmetic model with a countdown for latency,
// compared every cycle, plus literal results for the key vectors.
module tb_ex_muldiv;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, stall_o, done_o;

  int vectors = 0;
  int errors  = 0;

  ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain 64-bit arithmetic; / and % truncate toward zero
  function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint          sa = $signed(rs);
    longint          sb = $signed(rt);
    longint unsigned ua = rs;
    longint unsigned ub = rt;
    logic [63:0] p, q, r;
    p = '0;
    case (op)
      3'd1: p = sa * sb;
      3'd2: p = ua * ub;
      3'd3, 3'd4: begin
        if (rt == 0) p = {rs, 32'hFFFF_FFFF};
        else begin
          if (op == 3'd3) begin q = sa / sb; r = sa % sb; end
          else            begin q = ua / ub; r = ua % ub; end
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_rem;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; m_rem <= 0;
      p_hi <= 0; p_lo <= 0;
    end else begin
      m_done <= 0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1; m_busy <= 0;
        end
      end else if (start_i) begin
        case (op_i)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            {p_hi, p_lo} <= model_op(op_i, rs_data_i, rt_data_i);
            m_rem  <= 33;
            m_busy <= 1;
          end
          3'd5: m_hi <= rs_data_i;
          3'd6: m_lo <= rs_data_i;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_i) begin
    logic exp_stall;
    exp_stall = m_busy || (start_i && op_i >= 3'd1 && op_i <= 3'd4);
    check("hi", hi_o, m_hi);
    check("lo", lo_o, m_lo);
    check("busy", 32'(busy_o), 32'(m_busy));
    check("done", 32'(done_o), 32'(m_done));
    check("stall", 32'(stall_o), 32'(exp_stall));
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk_i); #1;
    start_i = 1; op_i = op; rs_data_i = rs; rt_data_i = rt;
    #1 check("stall_start", 32'(stall_o), 32'(op >= 3'd1 && op <= 3'd4));
    @(posedge clk_i); #1;
    start_i = 0; op_i = 0;
  endtask

  task automatic wait_done(input int lat, input logic [31:0] eh, input logic [31:0] el);
    int k = 0;
    forever begin
      @(negedge clk_i);
      if (done_o || k >= 40) break;
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("hi_lit", hi_o, eh);
    check("lo_lit", lo_o, el);
    check("model_hi_lit", m_hi, eh);
    check("model_lo_lit", m_lo, el);
    @(negedge clk_i);
    check("done_pulse", 32'(done_o), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] eh, input logic [31:0] el);
    issue(op, rs, rt);
    wait_done(33, eh, el);
  endtask

  initial begin
    rst_i = 0; start_i = 0; op_i = 0; rs_data_i = 0; rt_data_i = 0;
    #12;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    @(posedge clk_i); #1 rst_i = 1;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(3'd4, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI then MTLO on consecutive edges
    @(posedge clk_i); #1;
    start_i = 1; op_i = 3'd5; rs_data_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    check("mthi", hi_o, 32'h1234_5678);
    op_i = 3'd6; rs_data_i = 32'h9ABC_DEF0;
    @(posedge clk_i); #1;
    check("mtlo", lo_o, 32'h9ABC_DEF0);
    check("mt_busy", 32'(busy_o), 0);
    start_i = 0; op_i = 0;

    // reserved op leaves everything alone
    issue(3'd7, 32'hDEAD_BEEF, 32'd3);
    repeat (3) @(negedge clk_i);
    check("op7_hi", hi_o, 32'h1234_5678);

    // operands and start_i toggling during CALC must be ignored
    issue(3'd1, 32'h0000_1234, 32'h0000_5678);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      rs_data_i = $urandom; rt_data_i = $urandom;
      start_i = 1'($urandom_range(0, 1)); op_i = 3'($urandom_range(0, 7));
    end
    @(posedge clk_i); #1 start_i = 0; op_i = 0;
    wait_done(12, 32'h0000_0000, 32'h0626_0060);

    // async reset in the middle of CALC aborts the op
    issue(3'd2, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk_i);
    #2 rst_i = 0;
    #1;
    check("abort_busy", 32'(busy_o), 0);
    check("abort_stall", 32'(stall_o), 0);
    check("abort_hi", hi_o, 0);
    check("abort_lo", lo_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    repeat (3) @(negedge clk_i);
    check("abort_no_done", 32'(done_o), 0);
    run_op(3'd4, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
